// File: rtl/register_file_scoreboard.sv
// register_file_scoreboard
//   Architectural register file fed by the write-back bus, paired with a
//   per-register count of writes that have been issued but not yet written
//   back. It sits in decode/operand fetch. It supplies the A and B operands
//   with a same-cycle write-back bypass. It stalls decode while an operand
//   still has an in-flight producer, or when the destination counter of an
//   issuing instruction is already full.
//
// Ports
//   CLK, RST_N          clock; asynchronous active-low reset
//   RW, DA, Bus_D       write-back enable / destination / data
//   AA, BA              operand A / B addresses
//   USE_A, USE_B        decode instruction actually reads A / B
//   ISSUE               decode instruction leaves decode this cycle unless stalled
//   ISSUE_RW, ISSUE_DA  issuing instruction writes a register / its destination
//   A_DATA, B_DATA      operands (combinational, bypassed)
//   STALL               hold decode (combinational)
//   SB_ERR              sticky flag: write-back arrived for a register with no
//                       outstanding write
module register_file_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RW,
  input  logic [ADDR_W-1:0] DA,
  input  logic [DATA_W-1:0] Bus_D,
  input  logic [ADDR_W-1:0] AA,
  input  logic [ADDR_W-1:0] BA,
  input  logic              USE_A,
  input  logic              USE_B,
  input  logic              ISSUE,
  input  logic              ISSUE_RW,
  input  logic [ADDR_W-1:0] ISSUE_DA,
  output logic [DATA_W-1:0] A_DATA,
  output logic [DATA_W-1:0] B_DATA,
  output logic              STALL,
  output logic              SB_ERR
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Flop-based array: the operand reads must be combinational, and every
  // entry has to clear on reset.
  logic [DATA_W-1:0] regs_reg [NREG];
  logic [CNT_W-1:0]  cnt_reg  [NREG];
  logic              sb_err_reg;

  logic             wb_en;
  logic [CNT_W-1:0] cnt_a, cnt_b, cnt_da, cnt_issue;
  logic             busy_a, busy_b, sat_stall;
  logic             stall_next;
  logic             inc, dec, err_set;

  assign wb_en     = RW && (DA != '0);
  assign cnt_a     = cnt_reg[AA];
  assign cnt_b     = cnt_reg[BA];
  assign cnt_da    = cnt_reg[DA];
  assign cnt_issue = cnt_reg[ISSUE_DA];

  // A register whose only outstanding write is arriving on the bus right now
  // is served by the bypass, so it does not count as busy.
  assign busy_a = (AA != '0) && (cnt_a != '0) &&
                  !((cnt_a == CNT_ONE) && wb_en && (DA == AA));
  assign busy_b = (BA != '0) && (cnt_b != '0) &&
                  !((cnt_b == CNT_ONE) && wb_en && (DA == BA));

  // A full counter must not take another increment, so the issuer waits.
  assign sat_stall = ISSUE && ISSUE_RW && (ISSUE_DA != '0) && (cnt_issue == CNT_MAX);

  assign stall_next = (USE_A && busy_a) || (USE_B && busy_b) || sat_stall;

  assign inc     = ISSUE && !stall_next && ISSUE_RW && (ISSUE_DA != '0);
  assign dec     = wb_en && (cnt_da != '0);
  assign err_set = wb_en && (cnt_da == '0);

  // R0 is covered by this loop too. wb_en and inc both exclude address 0,
  // so entry 0 never leaves its reset value.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      logic inc_hit, dec_hit;
      assign inc_hit = inc && (ISSUE_DA == ADDR_W'(gi));
      assign dec_hit = dec && (DA == ADDR_W'(gi));

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          regs_reg[gi] <= '0;
          cnt_reg[gi]  <= '0;
        end else begin
          if (wb_en && (DA == ADDR_W'(gi)))
            regs_reg[gi] <= Bus_D;
          // An increment and a decrement on the same register cancel out.
          if (inc_hit && !dec_hit)
            cnt_reg[gi] <= cnt_reg[gi] + CNT_ONE;
          else if (dec_hit && !inc_hit)
            cnt_reg[gi] <= cnt_reg[gi] - CNT_ONE;
        end
      end
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      sb_err_reg <= 1'b0;
    else if (err_set)
      sb_err_reg <= 1'b1;
  end

  assign A_DATA = (AA == '0) ? '0 : (wb_en && (DA == AA)) ? Bus_D : regs_reg[AA];
  assign B_DATA = (BA == '0) ? '0 : (wb_en && (DA == BA)) ? Bus_D : regs_reg[BA];
  assign STALL  = stall_next;
  assign SB_ERR = sb_err_reg;

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Directed bench for register_file_scoreboard. Inputs change 1 ns after each
// rising edge. Outputs are checked 1 ns after that, well away from the edge.
module tb_register_file_scoreboard;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        RW;
  logic [4:0]  DA;
  logic [31:0] Bus_D;
  logic [4:0]  AA, BA;
  logic        USE_A, USE_B;
  logic        ISSUE, ISSUE_RW;
  logic [4:0]  ISSUE_DA;
  logic [31:0] A_DATA, B_DATA;
  logic        STALL, SB_ERR;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int check_cnt = 0;

  register_file_scoreboard #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .RW(RW), .DA(DA), .Bus_D(Bus_D),
    .AA(AA), .BA(BA), .USE_A(USE_A), .USE_B(USE_B),
    .ISSUE(ISSUE), .ISSUE_RW(ISSUE_RW), .ISSUE_DA(ISSUE_DA),
    .A_DATA(A_DATA), .B_DATA(B_DATA), .STALL(STALL), .SB_ERR(SB_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    RW = 0; DA = 0; Bus_D = 0; AA = 0; BA = 0;
    USE_A = 0; USE_B = 0; ISSUE = 0; ISSUE_RW = 0; ISSUE_DA = 0;
  endtask

  // Advance one clock, then let inputs settle.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue_to(input logic [4:0] d);
    idle(); ISSUE = 1; ISSUE_RW = 1; ISSUE_DA = d;
  endtask

  task automatic wb(input logic [4:0] d, input logic [31:0] v);
    idle(); RW = 1; DA = d; Bus_D = v;
  endtask

  initial begin
    idle();
    RST_N = 0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1;
    #1;

    // 1: all registers read zero after reset
    $display("step reset-read-all");
    for (int i = 0; i < 32; i++) begin
      AA = 5'(i); BA = 5'(31 - i); USE_A = 1; USE_B = 1;
      #1;
      check($sformatf("rst_a[%0d]", i), A_DATA, 32'h0);
      check($sformatf("rst_b[%0d]", 31 - i), B_DATA, 32'h0);
      check($sformatf("rst_stall[%0d]", i), {31'b0, STALL}, 32'h0);
    end
    check("rst_sb_err", {31'b0, SB_ERR}, 32'h0);

    // 2: same-cycle bypass and register hold; the write to R0 is discarded
    $display("step bypass");
    issue_to(5); #1;
    check("iss5_stall", {31'b0, STALL}, 32'h0);
    cyc();
    wb(5, 32'hDEADBEEF); AA = 5; USE_A = 1; #1;
    check("bypass_a5", A_DATA, 32'hDEADBEEF);
    check("bypass_stall5", {31'b0, STALL}, 32'h0);
    cyc();
    idle(); AA = 5; BA = 5; USE_A = 1; USE_B = 1; #1;
    check("hold_a5", A_DATA, 32'hDEADBEEF);
    check("hold_b5", B_DATA, 32'hDEADBEEF);
    check("hold_stall5", {31'b0, STALL}, 32'h0);
    wb(0, 32'h12345678); AA = 0; #1;
    check("r0_bypass", A_DATA, 32'h0);
    cyc();
    idle(); AA = 0; #1;
    check("r0_hold", A_DATA, 32'h0);
    check("sb_err_clean", {31'b0, SB_ERR}, 32'h0);

    // 3: a read-after-write stall lasts until the write-back cycle
    $display("step raw-stall");
    issue_to(7); #1;
    check("iss7_stall", {31'b0, STALL}, 32'h0);
    cyc();
    idle(); USE_A = 1; AA = 7; ISSUE = 1; ISSUE_RW = 1; ISSUE_DA = 8; #1;
    check("raw7_stall_c1", {31'b0, STALL}, 32'h1);
    cyc();
    #1;
    check("raw7_stall_c2", {31'b0, STALL}, 32'h1);
    RW = 1; DA = 7; Bus_D = 32'hCAFEF00D; #1;
    check("raw7_release", {31'b0, STALL}, 32'h0);
    check("raw7_bypass", A_DATA, 32'hCAFEF00D);
    cyc();
    idle(); USE_B = 1; BA = 8; #1;
    check("cnt8_one_busy", {31'b0, STALL}, 32'h1);
    RW = 1; DA = 8; Bus_D = 32'h88; #1;
    check("cnt8_release", {31'b0, STALL}, 32'h0);
    check("cnt8_bypass", B_DATA, 32'h88);
    cyc();

    // 4: counter saturation at 3
    $display("step saturation");
    for (int k = 0; k < 3; k++) begin
      issue_to(3); #1;
      check($sformatf("iss3_%0d", k), {31'b0, STALL}, 32'h0);
      cyc();
    end
    issue_to(3); #1;
    check("iss3_sat_stall", {31'b0, STALL}, 32'h1);
    cyc();
    wb(3, 32'h31); USE_A = 1; AA = 3; #1;
    check("drain3_cnt3", {31'b0, STALL}, 32'h1);
    cyc();
    wb(3, 32'h32); USE_A = 1; AA = 3; #1;
    check("drain3_cnt2", {31'b0, STALL}, 32'h1);
    cyc();
    wb(3, 32'h33); USE_A = 1; AA = 3; #1;
    check("drain3_cnt1", {31'b0, STALL}, 32'h0);
    cyc();
    idle(); USE_A = 1; AA = 3; #1;
    check("drain3_cnt0", {31'b0, STALL}, 32'h0);
    check("drain3_data", A_DATA, 32'h33);

    // 5: inc and dec together, on the same register and on different ones
    $display("step inc-dec");
    issue_to(9); cyc();
    issue_to(9); RW = 1; DA = 9; Bus_D = 32'h99; #1;
    check("same9_stall", {31'b0, STALL}, 32'h0);
    cyc();
    idle(); USE_A = 1; AA = 9; #1;
    check("same9_busy", {31'b0, STALL}, 32'h1);
    RW = 1; DA = 9; Bus_D = 32'h9A; #1;
    check("same9_cnt_one", {31'b0, STALL}, 32'h0);
    cyc();
    issue_to(10); cyc();
    issue_to(11); RW = 1; DA = 10; Bus_D = 32'hA0; #1;
    check("diff_stall", {31'b0, STALL}, 32'h0);
    cyc();
    idle(); USE_A = 1; AA = 10; #1;
    check("diff_cnt10_zero", {31'b0, STALL}, 32'h0);
    USE_B = 1; BA = 11; #1;
    check("diff_cnt11_one", {31'b0, STALL}, 32'h1);
    check("diff_sb_err", {31'b0, SB_ERR}, 32'h0);
    wb(11, 32'hB0); cyc();

    // 6: unmatched write-back sets the sticky error; async reset clears all
    $display("step sb-err-reset");
    wb(12, 32'h12121212); cyc();
    idle(); AA = 12; #1;
    check("err_set", {31'b0, SB_ERR}, 32'h1);
    check("err_data12", A_DATA, 32'h12121212);
    cyc();
    check("err_sticky", {31'b0, SB_ERR}, 32'h1);
    issue_to(13); cyc();
    idle(); AA = 12; BA = 13; USE_B = 1; #1;
    check("pre_rst_stall13", {31'b0, STALL}, 32'h1);
    #1 RST_N = 0;
    #1;
    check("arst_sb_err", {31'b0, SB_ERR}, 32'h0);
    check("arst_a12", A_DATA, 32'h0);
    check("arst_stall13", {31'b0, STALL}, 32'h0);
    BA = 5; #1;
    check("arst_b5", B_DATA, 32'h0);
    wb(6, 32'h66); cyc();
    idle(); AA = 6; #1;
    check("rst_blocks_write", A_DATA, 32'h0);
    RST_N = 1;
    cyc();
    check("post_rst_a6", A_DATA, 32'h0);
    check("post_rst_sb_err", {31'b0, SB_ERR}, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
